// File: rtl/pipe_tag_tracker.sv
// ---------------------------------------------------------------------------
// pipe_tag_tracker
//
// Tracks transactions down a STAGES-deep pipeline. Each transaction entering
// stage 0 gets a sequence tag; the tag moves down with the stage advance
// strobes. Each stage has a valid gate, a hold counter (cycles spent on the
// current tag) and a hang flag. A retire port checks that tags leave the last
// stage in program order.
//
// Ports:
//   clk          - clock, rising edge
//   rstn         - asynchronous active-low reset
//   stage_adv    - bit i: a transaction enters stage i this cycle
//   stage_kill   - bit i: the transaction in stage i is removed
//   retire       - the last stage completes its transaction this cycle
//   stage_tag    - gated tag per stage, stage i at [i*TAG_W +: TAG_W]
//   stage_valid  - valid gate per stage
//   hold_cnt     - cycles stage i has held its tag, [i*HOLD_W +: HOLD_W]
//   hang         - hold_cnt[i] >= HOLD_MAX while stage i is valid
//   retire_valid - a valid tag retired last cycle
//   retire_tag   - tag of that retirement
//   order_err    - sticky out-of-order / duplicate retirement flag
// ---------------------------------------------------------------------------
module pipe_tag_tracker #(
    parameter int STAGES   = 5,
    parameter int TAG_W    = 6,
    parameter int HOLD_W   = 6,
    parameter int HOLD_MAX = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [STAGES-1:0]          stage_adv,
    input  logic [STAGES-1:0]          stage_kill,
    input  logic                       retire,
    output logic [STAGES*TAG_W-1:0]    stage_tag,
    output logic [STAGES-1:0]          stage_valid,
    output logic [STAGES*HOLD_W-1:0]   hold_cnt,
    output logic [STAGES-1:0]          hang,
    output logic                       retire_valid,
    output logic [TAG_W-1:0]           retire_tag,
    output logic                       order_err
);

    localparam logic [TAG_W-1:0]  TAG_MAX  = '1;
    localparam logic [TAG_W-1:0]  TAG_ONE  = TAG_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
    // Forward distance of half the tag space or more is treated as going
    // backwards (or jumping implausibly far ahead).
    localparam logic [TAG_W:0]    HALF     = (TAG_W+1)'(1) << (TAG_W-1);

    logic [STAGES-1:0][TAG_W-1:0]  raw_tag_q, raw_tag_d;
    logic [STAGES-1:0][TAG_W-1:0]  src_tag;
    logic [STAGES-1:0]             src_valid;
    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0][HOLD_W-1:0] hold_q, hold_d;

    logic [TAG_W-1:0] next_tag_q, next_tag_d;
    logic             first_ret_q, first_ret_d;
    logic [TAG_W-1:0] last_ret_q, last_ret_d;
    logic             retire_valid_q, retire_valid_d;
    logic [TAG_W-1:0] retire_tag_q, retire_tag_d;
    logic             order_err_q, order_err_d;

    // ---------------------------------------------------------------
    // Per-stage tag / valid / hold logic
    // ---------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign src_tag[gi]   = next_tag_q;
                assign src_valid[gi] = 1'b1;
            end else begin : g_body
                // Pre-edge values of the upstream stage, so simultaneous
                // advances on neighbouring stages shift cleanly.
                assign src_tag[gi]   = raw_tag_q[gi-1];
                assign src_valid[gi] = valid_q[gi-1];
            end

            // Advance takes priority over kill on the same stage.
            assign raw_tag_d[gi] = stage_adv[gi] ? src_tag[gi] : raw_tag_q[gi];
            assign valid_d[gi]   = stage_adv[gi] ? src_valid[gi]
                                                 : (valid_q[gi] & ~stage_kill[gi]);

            assign hold_d[gi] = (stage_adv[gi] || !valid_d[gi]) ? '0 :
                                (hold_q[gi] == HOLD_SAT)        ? hold_q[gi] :
                                                                  hold_q[gi] + 1'b1;

            assign stage_tag[gi*TAG_W +: TAG_W]   = valid_q[gi] ? raw_tag_q[gi] : '0;
            assign hold_cnt[gi*HOLD_W +: HOLD_W]  = hold_q[gi];
            assign stage_valid[gi]                = valid_q[gi];
            assign hang[gi] = valid_q[gi] && (hold_q[gi] >= HOLD_LIM);
        end
    endgenerate

    // ---------------------------------------------------------------
    // Tag allocator: 1..2^TAG_W-1, skipping the reserved empty tag 0
    // ---------------------------------------------------------------
    always_comb begin
        next_tag_d = next_tag_q;
        if (stage_adv[0]) begin
            next_tag_d = (next_tag_q == TAG_MAX) ? TAG_ONE : next_tag_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Retirement and order check
    // ---------------------------------------------------------------
    logic [TAG_W-1:0] ret_tag;
    logic [TAG_W:0]   ret_dist;
    logic             ret_ok;

    assign ret_tag = raw_tag_q[STAGES-1];
    assign ret_ok  = retire && valid_q[STAGES-1];

    always_comb begin
        // Distance from the previous retirement, modulo the 2^TAG_W-1 tags
        // in use (0 is never allocated, so the wrap adds M, not 2^TAG_W).
        ret_dist = {1'b0, ret_tag} - {1'b0, last_ret_q};
        if (ret_tag < last_ret_q) begin
            ret_dist = ret_dist + {1'b0, TAG_MAX};
        end
    end

    always_comb begin
        retire_valid_d = ret_ok;
        retire_tag_d   = retire_tag_q;
        first_ret_d    = first_ret_q;
        last_ret_d     = last_ret_q;
        order_err_d    = order_err_q;
        if (ret_ok) begin
            retire_tag_d = ret_tag;
            last_ret_d   = ret_tag;
            first_ret_d  = 1'b0;
            if (!first_ret_q && (ret_dist == '0 || ret_dist >= HALF)) begin
                order_err_d = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            raw_tag_q      <= '0;
            valid_q        <= '0;
            hold_q         <= '0;
            next_tag_q     <= TAG_ONE;
            first_ret_q    <= 1'b1;
            last_ret_q     <= '0;
            retire_valid_q <= 1'b0;
            retire_tag_q   <= '0;
            order_err_q    <= 1'b0;
        end else begin
            raw_tag_q      <= raw_tag_d;
            valid_q        <= valid_d;
            hold_q         <= hold_d;
            next_tag_q     <= next_tag_d;
            first_ret_q    <= first_ret_d;
            last_ret_q     <= last_ret_d;
            retire_valid_q <= retire_valid_d;
            retire_tag_q   <= retire_tag_d;
            order_err_q    <= order_err_d;
        end
    end

    assign retire_valid = retire_valid_q;
    assign retire_tag   = retire_tag_q;
    assign order_err    = order_err_q;

endmodule

// File: tb/tb_pipe_tag_tracker.sv
// ---------------------------------------------------------------------------
// tb_pipe_tag_tracker
//
// Directed bench: a table of per-cycle vectors for tag shifting, gating,
// adv/kill priority and retirement on the default 5-stage, 6-bit tracker,
// plus hand-written sequences for hold/hang counting, duplicate retirement,
// mid-operation reset, and tag wrap / order distance on a 2-stage, 3-bit
// tracker.
// ---------------------------------------------------------------------------
module tb_pipe_tag_tracker;

    logic clk;
    logic rstn;

    // Default instance: STAGES=5, TAG_W=6, HOLD_W=6, HOLD_MAX=32
    logic [4:0]  adv, kill;
    logic        ret;
    logic [29:0] stage_tag;
    logic [4:0]  stage_valid;
    logic [29:0] hold_cnt;
    logic [4:0]  hang;
    logic        retire_valid;
    logic [5:0]  retire_tag;
    logic        order_err;

    // Small instance: STAGES=2, TAG_W=3
    logic [1:0]  adv3, kill3;
    logic        ret3;
    logic [5:0]  stage_tag3;
    logic [1:0]  stage_valid3;
    logic [11:0] hold_cnt3;
    logic [1:0]  hang3;
    logic        retire_valid3;
    logic [2:0]  retire_tag3;
    logic        order_err3;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_tag_tracker dut (
        .clk          (clk),
        .rstn         (rstn),
        .stage_adv    (adv),
        .stage_kill   (kill),
        .retire       (ret),
        .stage_tag    (stage_tag),
        .stage_valid  (stage_valid),
        .hold_cnt     (hold_cnt),
        .hang         (hang),
        .retire_valid (retire_valid),
        .retire_tag   (retire_tag),
        .order_err    (order_err)
    );

    pipe_tag_tracker #(.STAGES(2), .TAG_W(3), .HOLD_W(6), .HOLD_MAX(32)) dut3 (
        .clk          (clk),
        .rstn         (rstn),
        .stage_adv    (adv3),
        .stage_kill   (kill3),
        .retire       (ret3),
        .stage_tag    (stage_tag3),
        .stage_valid  (stage_valid3),
        .hold_cnt     (hold_cnt3),
        .hang         (hang3),
        .retire_valid (retire_valid3),
        .retire_tag   (retire_tag3),
        .order_err    (order_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic zero_inputs();
        adv = '0; kill = '0; ret = 1'b0;
        adv3 = '0; kill3 = '0; ret3 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        zero_inputs();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // One cycle on the default instance; outputs sampled 1 time unit after the edge.
    task automatic step(input logic [4:0] a, input logic [4:0] k, input logic r);
        @(negedge clk);
        adv = a; kill = k; ret = r;
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic [1:0] a, input logic [1:0] k, input logic r);
        @(negedge clk);
        adv3 = a; kill3 = k; ret3 = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] hold_of(input int i);
        return hold_cnt[i*6 +: 6];
    endfunction

    typedef struct {
        logic [4:0]  adv;
        logic [4:0]  kill;
        logic        ret;
        logic [29:0] tags;
        logic [4:0]  valid;
        logic        rv;
        logic [5:0]  rtag;
        logic        err;
    } vec_t;

    function automatic logic [29:0] pk(input int t4, input int t3, input int t2,
                                       input int t1, input int t0);
        return {6'(t4), 6'(t3), 6'(t2), 6'(t1), 6'(t0)};
    endfunction

    vec_t tbl [13];

    initial begin
        // adv, kill, ret, expected tags {s4..s0}, valid, retire_valid, retire_tag, order_err
        tbl[0]  = '{5'b00001, 5'b00000, 1'b0, pk(0,0,0,0,1), 5'b00001, 1'b0, 6'd0, 1'b0};
        tbl[1]  = '{5'b00001, 5'b00000, 1'b0, pk(0,0,0,0,2), 5'b00001, 1'b0, 6'd0, 1'b0};
        tbl[2]  = '{5'b00001, 5'b00000, 1'b0, pk(0,0,0,0,3), 5'b00001, 1'b0, 6'd0, 1'b0};
        tbl[3]  = '{5'b00010, 5'b00001, 1'b0, pk(0,0,0,3,0), 5'b00010, 1'b0, 6'd0, 1'b0};
        tbl[4]  = '{5'b00100, 5'b00010, 1'b0, pk(0,0,3,0,0), 5'b00100, 1'b0, 6'd0, 1'b0};
        tbl[5]  = '{5'b01000, 5'b00100, 1'b0, pk(0,3,0,0,0), 5'b01000, 1'b0, 6'd0, 1'b0};
        tbl[6]  = '{5'b10000, 5'b01000, 1'b0, pk(3,0,0,0,0), 5'b10000, 1'b0, 6'd0, 1'b0};
        tbl[7]  = '{5'b00000, 5'b00000, 1'b1, pk(3,0,0,0,0), 5'b10000, 1'b1, 6'd3, 1'b0};
        tbl[8]  = '{5'b00000, 5'b10000, 1'b0, pk(0,0,0,0,0), 5'b00000, 1'b0, 6'd0, 1'b0};
        // Stage 1 copies the invalid (but stale raw 3) stage 0: gated to 0.
        tbl[9]  = '{5'b00011, 5'b00000, 1'b0, pk(0,0,0,0,4), 5'b00001, 1'b0, 6'd0, 1'b0};
        tbl[10] = '{5'b00011, 5'b00000, 1'b0, pk(0,0,0,4,5), 5'b00011, 1'b0, 6'd0, 1'b0};
        // Same-cycle adv and kill on stage 1: advance wins.
        tbl[11] = '{5'b00010, 5'b00010, 1'b0, pk(0,0,0,5,5), 5'b00011, 1'b0, 6'd0, 1'b0};
        // Retire with the last stage empty is ignored.
        tbl[12] = '{5'b00000, 5'b00000, 1'b1, pk(0,0,0,5,5), 5'b00011, 1'b0, 6'd0, 1'b0};

        rstn = 1'b0;
        zero_inputs();
        repeat (2) @(negedge clk);

        // ---- Reset state ----
        chk("rst stage_tag",    32'(stage_tag),    32'd0);
        chk("rst stage_valid",  32'(stage_valid),  32'd0);
        chk("rst hold_cnt",     32'(hold_cnt),     32'd0);
        chk("rst hang",         32'(hang),         32'd0);
        chk("rst retire_valid", 32'(retire_valid), 32'd0);
        chk("rst retire_tag",   32'(retire_tag),   32'd0);
        chk("rst order_err",    32'(order_err),    32'd0);
        rstn = 1'b1;

        // ---- Table vectors ----
        for (int v = 0; v < 13; v++) begin
            step(tbl[v].adv, tbl[v].kill, tbl[v].ret);
            chk($sformatf("vec%0d stage_tag", v),    32'(stage_tag),    32'(tbl[v].tags));
            chk($sformatf("vec%0d stage_valid", v),  32'(stage_valid),  32'(tbl[v].valid));
            chk($sformatf("vec%0d retire_valid", v), 32'(retire_valid), 32'(tbl[v].rv));
            if (tbl[v].rv)
                chk($sformatf("vec%0d retire_tag", v), 32'(retire_tag), 32'(tbl[v].rtag));
            chk($sformatf("vec%0d order_err", v),    32'(order_err),    32'(tbl[v].err));
        end

        // ---- Hold counter, hang threshold and saturation on stage 2 ----
        do_reset();
        step(5'b00001, 5'b0, 1'b0);
        step(5'b00010, 5'b0, 1'b0);
        step(5'b00100, 5'b0, 1'b0);
        chk("hold load tag2", 32'(stage_tag[12 +: 6]), 32'd1);
        chk("hold load cnt2", 32'(hold_of(2)),        32'd0);
        for (int k = 1; k <= 70; k++) begin
            int e;
            step(5'b0, 5'b0, 1'b0);
            e = (k > 63) ? 63 : k;
            chk($sformatf("hold cnt2 k=%0d", k),  32'(hold_of(2)), 32'(e));
            chk($sformatf("hang2 k=%0d", k),      32'(hang[2]),    32'(e >= 32));
        end
        step(5'b0, 5'b00100, 1'b0);
        chk("kill2 valid", 32'(stage_valid[2]), 32'd0);
        chk("kill2 hold",  32'(hold_of(2)),     32'd0);
        chk("kill2 hang",  32'(hang[2]),        32'd0);
        chk("kill2 tag",   32'(stage_tag[12 +: 6]), 32'd0);

        // ---- Duplicate retirement, sticky error, mid-cycle reset ----
        do_reset();
        repeat (4) step(5'b00001, 5'b0, 1'b0);
        step(5'b00010, 5'b0, 1'b0);
        step(5'b00100, 5'b0, 1'b0);
        step(5'b01000, 5'b0, 1'b0);
        step(5'b10000, 5'b0, 1'b0);
        chk("dup tag4", 32'(stage_tag[24 +: 6]), 32'd4);
        step(5'b0, 5'b0, 1'b1);
        chk("dup ret1 valid", 32'(retire_valid), 32'd1);
        chk("dup ret1 tag",   32'(retire_tag),   32'd4);
        chk("dup ret1 err",   32'(order_err),    32'd0);
        step(5'b0, 5'b0, 1'b1);
        chk("dup ret2 valid", 32'(retire_valid), 32'd1);
        chk("dup ret2 tag",   32'(retire_tag),   32'd4);
        chk("dup ret2 err",   32'(order_err),    32'd1);
        for (int k = 0; k < 3; k++) begin
            step(5'b0, 5'b0, 1'b0);
            chk($sformatf("sticky err %0d", k), 32'(order_err),    32'd1);
            chk($sformatf("idle rv %0d", k),    32'(retire_valid), 32'd0);
        end
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async rst err",   32'(order_err),   32'd0);
        chk("async rst valid", 32'(stage_valid), 32'd0);
        chk("async rst tag",   32'(stage_tag),   32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step(5'b00001, 5'b0, 1'b0);
        chk("post rst tag0", 32'(stage_tag[0 +: 6]), 32'd1);

        // ---- TAG_W=3: wrap 1..7,1 with in-order retirement ----
        do_reset();
        begin
            logic [2:0] e [10];
            logic [2:0] t;
            t = 3'd1;
            for (int c = 0; c < 10; c++) begin
                step3((c == 0) ? 2'b01 : 2'b11, 2'b00, c >= 2);
                e[c] = t;
                t = (t == 3'd7) ? 3'd1 : t + 3'd1;
                chk($sformatf("wrap s0 c=%0d", c), 32'(stage_tag3[0 +: 3]), 32'(e[c]));
                if (c >= 1)
                    chk($sformatf("wrap s1 c=%0d", c), 32'(stage_tag3[3 +: 3]), 32'(e[c-1]));
                chk($sformatf("wrap rv c=%0d", c), 32'(retire_valid3), 32'(c >= 2));
                if (c >= 2)
                    chk($sformatf("wrap rtag c=%0d", c), 32'(retire_tag3), 32'(e[c-2]));
                chk($sformatf("wrap err c=%0d", c), 32'(order_err3), 32'd0);
            end
        end

        // ---- TAG_W=3: distance 3 is legal, distance 4 (across wrap) flags ----
        do_reset();
        step3(2'b01, 2'b00, 1'b0);               // s0=1
        step3(2'b11, 2'b00, 1'b0);               // s0=2, s1=1
        step3(2'b00, 2'b00, 1'b1);               // retire 1 (first)
        chk("dist first rtag", 32'(retire_tag3), 32'd1);
        step3(2'b01, 2'b00, 1'b0);               // s0=3
        step3(2'b01, 2'b00, 1'b0);               // s0=4
        step3(2'b10, 2'b00, 1'b0);               // s1=4
        step3(2'b00, 2'b00, 1'b1);               // retire 4, d=3
        chk("dist3 rtag", 32'(retire_tag3), 32'd4);
        chk("dist3 err",  32'(order_err3),  32'd0);
        repeat (4) step3(2'b01, 2'b00, 1'b0);    // s0=5,6,7,1
        chk("dist wrap s0", 32'(stage_tag3[0 +: 3]), 32'd1);
        step3(2'b10, 2'b00, 1'b0);               // s1=1
        step3(2'b00, 2'b00, 1'b1);               // retire 1, d=1-4+7=4
        chk("dist4 rtag", 32'(retire_tag3), 32'd1);
        chk("dist4 err",  32'(order_err3),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
